can_rx_reader: RTL and testbench
================================

CAN_RX_READER -- requirements
Module: can_rx_reader

Interface
REQ-001 SHALL have parameter RST_IRQ, default 16'h8070, meaning the word written to the Canakari interrupt register to clear a receive interrupt.
REQ-002 SHALL have parameter IRQ_ADDR, default 5'b10010, meaning the Canakari interrupt register address.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rec_irq  input  1  Canakari receive interrupt; level, high = frame pending.
REQ-006 can_rec_select  input  5  bus id of the interrupting Canakari node.
REQ-007 read_can  input  16  Canakari read data; valid exactly one cycle after a read_en cycle.
REQ-008 rec_ready  input  1  downstream accepts the assembled message.
REQ-009 addr  output  5  Canakari register address.
REQ-010 read_en  output  1  one-cycle Canakari read strobe.
REQ-011 write_en  output  1  one-cycle Canakari write strobe.
REQ-012 write_can  output  16  Canakari write data.
REQ-013 rec_mes  output  76  assembled received message.
REQ-014 rec_bus_id  output  5  bus id latched for the current message.
REQ-015 rec_valid  output  1  rec_mes/rec_bus_id valid; held until accepted.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CAP, CLR, OUT, with a 3-bit register index idx (0..4).
REQ-018 In IDLE with rec_irq=1, SHALL latch can_rec_select into rec_bus_id, set idx=0, and go to RD; otherwise SHALL stay in IDLE.
REQ-019 Per idx, RD SHALL use these register addresses: 0 = 5'b00101 (RX ID), 1 = 5'b00100 (D1-2), 2 = 5'b00011 (D3-4), 3 = 5'b00010 (D5-6), 4 = 5'b00001 (D7-8).
REQ-020 RD SHALL assert read_en=1 with addr=table[idx] for exactly one cycle, then go to CAP.
REQ-021 CAP SHALL capture read_can into rec_mes using the mapping for idx:
- idx 0: [15:5]->[74:64]; read_can[4:0] is discarded.
- idx 1: [15:8]->[63:56], [7:0]->[47:40].
- idx 2: [15:8]->[55:48], [7:0]->[39:32].
- idx 3: [15:8]->[7:0], [7:0]->[15:8].
- idx 4: [15:8]->[23:16], [7:0]->[31:24].
REQ-022 rec_mes[75] SHALL always be 0.
REQ-023 From CAP, SHALL go to CLR if idx==4; otherwise SHALL increment idx and go to RD.
REQ-024 CLR SHALL assert write_en=1, addr=IRQ_ADDR, write_can=RST_IRQ for exactly one cycle, then go to OUT.
REQ-025 OUT SHALL hold rec_valid=1 with rec_mes and rec_bus_id stable.
REQ-026 In OUT, rec_ready=1 SHALL complete the transfer in that cycle, and the FSM SHALL return to IDLE with rec_valid=0 on the next edge; rec_ready in any other state SHALL be ignored.
REQ-027 Latency: with rec_irq sampled at edge 0, rec_valid SHALL rise after edge 12.
- RD/CAP pairs occupy edges 1-10.
- CLR occupies edge 11.
REQ-028 rec_irq SHALL be ignored outside IDLE; a still-high rec_irq in IDLE SHALL start a new frame (level-sensitive, no edge detection).
REQ-029 read_en and write_en SHALL never be high in the same cycle.
REQ-030 Outside RD and CLR: addr=0, read_en=0, write_en=0, write_can=0.
REQ-031 rec_mes and rec_bus_id SHALL change only in CAP and in IDLE-start respectively; they SHALL hold otherwise.

Reset
REQ-032 rst=1 SHALL immediately force:
- state=IDLE, idx=0;
- addr=0, read_en=0, write_en=0, write_can=0;
- rec_mes=0, rec_bus_id=0, rec_valid=0, busy=0.
REQ-033 Reset mid-frame SHALL discard the partial message; no CLR write SHALL be issued for that frame.
REQ-034 After rst deasserts, the first action SHALL be the IDLE evaluation on the next rising edge.

Verification
REQ-035 Bench SHALL cover the nominal frame.
- Stimulus: rec_irq=1, can_rec_select=5'h03; read_can per idx = 16'hABE0, 16'h1122, 16'h3344, 16'h5566, 16'h7788; rec_ready=1.
- Response: reads at addresses 05,04,03,02,01; write 16'h8070 to 5'h12; rec_valid at edge 12; rec_bus_id=5'h03; rec_mes=76'h0_55F_1133_2244_8877_6655.
REQ-036 Bench SHALL cover backpressure: rec_ready=0 for 20 cycles after rec_valid -> rec_valid and rec_mes held constant; rec_ready=1 -> IDLE next edge.
REQ-037 Bench SHALL cover reset mid-frame: rst pulse during CAP idx=2 -> all outputs 0 immediately; no write_en afterwards; next rec_irq restarts from addr 5'h05.
REQ-038 Bench SHALL cover an ignored interrupt: can_rec_select changed and rec_irq toggled during RD/CAP -> rec_bus_id keeps the value latched at start.
REQ-039 Bench SHALL cover back-to-back frames: rec_irq held high through OUT -> new frame starts on the edge after return to IDLE, with read_en at addr 5'h05.
REQ-040 Bench SHALL check throughout all scenarios that read_en and write_en are never high together and that each strobe lasts exactly one cycle.

Source files
------------

// File: rtl/can_rx_reader.sv
// rtl/can_rx_reader.sv - Canakari receive-frame reader: reads RX ID and data registers, clears the IRQ, presents the message.
module can_rx_reader #(
    parameter logic [15:0] RST_IRQ  = 16'h8070,
    parameter logic [4:0]  IRQ_ADDR = 5'b10010
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        rec_irq,
    input  logic [4:0]  can_rec_select,
    input  logic [15:0] read_can,
    input  logic        rec_ready,
    output logic [4:0]  addr,
    output logic        read_en,
    output logic        write_en,
    output logic [15:0] write_can,
    output logic [75:0] rec_mes,
    output logic [4:0]  rec_bus_id,
    output logic        rec_valid,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RD, CAP, CLR, OUT} state_t;

    state_t     state;
    logic [2:0] idx;

    function automatic logic [4:0] rd_addr(input logic [2:0] i);
        case (i)
            3'd0:    rd_addr = 5'b00101;
            3'd1:    rd_addr = 5'b00100;
            3'd2:    rd_addr = 5'b00011;
            3'd3:    rd_addr = 5'b00010;
            3'd4:    rd_addr = 5'b00001;
            default: rd_addr = 5'b00000;
        endcase
    endfunction

    // Strobes and address are registered on entry to RD/CLR so they last exactly that state's cycle.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            addr       <= 5'd0;
            read_en    <= 1'b0;
            write_en   <= 1'b0;
            write_can  <= 16'd0;
            rec_mes    <= 76'd0;
            rec_bus_id <= 5'd0;
            rec_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            addr      <= 5'd0;
            read_en   <= 1'b0;
            write_en  <= 1'b0;
            write_can <= 16'd0;
            case (state)
                IDLE: begin
                    if (rec_irq) begin
                        rec_bus_id <= can_rec_select;
                        idx        <= 3'd0;
                        state      <= RD;
                        busy       <= 1'b1;
                        read_en    <= 1'b1;
                        addr       <= rd_addr(3'd0);
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    case (idx)
                        3'd0: rec_mes[74:64] <= read_can[15:5];
                        3'd1: begin
                            rec_mes[63:56] <= read_can[15:8];
                            rec_mes[47:40] <= read_can[7:0];
                        end
                        3'd2: begin
                            rec_mes[55:48] <= read_can[15:8];
                            rec_mes[39:32] <= read_can[7:0];
                        end
                        3'd3: begin
                            rec_mes[7:0]  <= read_can[15:8];
                            rec_mes[15:8] <= read_can[7:0];
                        end
                        3'd4: begin
                            rec_mes[23:16] <= read_can[15:8];
                            rec_mes[31:24] <= read_can[7:0];
                        end
                        default: ;
                    endcase
                    if (idx == 3'd4) begin
                        state     <= CLR;
                        write_en  <= 1'b1;
                        addr      <= IRQ_ADDR;
                        write_can <= RST_IRQ;
                    end else begin
                        idx     <= idx + 3'd1;
                        state   <= RD;
                        read_en <= 1'b1;
                        addr    <= rd_addr(idx + 3'd1);
                    end
                end
                CLR: begin
                    state <= OUT;
                end
                OUT: begin
                    // Valid rises one cycle into OUT, after the interrupt clear has been issued.
                    if (!rec_valid) begin
                        rec_valid <= 1'b1;
                    end else if (rec_ready) begin
                        rec_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_rx_reader.sv
// tb/tb_can_rx_reader.sv - Self-checking bench for can_rx_reader against a frame-timeline model.
module tb_can_rx_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_irq = 1'b0;
    logic [4:0]  sel = 5'd0;
    logic [15:0] read_can = 16'd0;
    logic        rec_ready = 1'b0;
    logic [4:0]  addr;
    logic        read_en;
    logic        write_en;
    logic [15:0] write_can;
    logic [75:0] rec_mes;
    logic [4:0]  rec_bus_id;
    logic        rec_valid;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    can_rx_reader dut (
        .clock(clk), .rst(rst), .rec_irq(rec_irq), .can_rec_select(sel),
        .read_can(read_can), .rec_ready(rec_ready), .addr(addr), .read_en(read_en),
        .write_en(write_en), .write_can(write_can), .rec_mes(rec_mes),
        .rec_bus_id(rec_bus_id), .rec_valid(rec_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: a frame is a timeline; m_j counts edges since the starting edge.
    logic [4:0]  tbl [5] = '{5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    logic        m_act = 1'b0;
    int          m_j = 0;
    logic [4:0]  m_bus = 5'd0;
    logic [15:0] m_w [5] = '{default: 16'd0};
    logic [15:0] fdata [5] = '{default: 16'd0};

    function automatic logic [75:0] assemble();
        return {1'b0, m_w[0][15:5], m_w[1][15:8], m_w[2][15:8], m_w[1][7:0], m_w[2][7:0],
                m_w[4][7:0], m_w[4][15:8], m_w[3][7:0], m_w[3][15:8]};
    endfunction

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0;
            m_j   = 0;
            m_bus = 5'd0;
            for (int i = 0; i < 5; i++) m_w[i] = 16'd0;
        end else if (!m_act) begin
            if (rec_irq) begin
                m_act = 1'b1;
                m_j   = 0;
                m_bus = sel;
            end
        end else if (m_j >= 12 && rec_ready) begin
            m_act = 1'b0;
        end else begin
            if (m_j % 2 == 1 && m_j <= 9) m_w[(m_j - 1) / 2] = read_can;
            if (m_j < 12) m_j++;
        end
    end

    logic       e_rd, e_wr, prev_rd = 1'b0, prev_wr = 1'b0;
    logic [4:0] e_addr;

    always @(negedge clk) begin
        e_rd   = m_act && m_j <= 8 && (m_j % 2 == 0);
        e_wr   = m_act && m_j == 10;
        e_addr = 5'd0;
        if (e_rd) e_addr = tbl[m_j / 2];
        else if (e_wr) e_addr = 5'h12;
        chk("read_en", read_en, e_rd);
        chk("write_en", write_en, e_wr);
        chk("addr", addr, e_addr);
        chk("write_can", write_can, e_wr ? 16'h8070 : 16'h0);
        chk("rec_valid", rec_valid, m_act && m_j >= 12);
        chk("busy", busy, m_act);
        chk("rec_mes", rec_mes, assemble());
        chk("rec_bus_id", rec_bus_id, m_bus);
        chk("rd_wr_exclusive", read_en & write_en, 1'b0);
        chk("read_en_one_cycle", read_en & prev_rd, 1'b0);
        chk("write_en_one_cycle", write_en & prev_wr, 1'b0);
        prev_rd = read_en;
        prev_wr = write_en;
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (m_act && m_j % 2 == 1 && m_j <= 9) read_can = fdata[(m_j - 1) / 2];
        else read_can = 16'($urandom);
    endtask

    task automatic rand_data();
        for (int i = 0; i < 5; i++) fdata[i] = 16'($urandom);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && rec_valid !== 1'b1; i++) step();
        chk("valid_timeout", rec_valid, 1'b1);
    endtask

    task automatic wait_idle();
        rec_irq = 1'b0;
        rec_ready = 1'b1;
        for (int i = 0; i < 40 && busy !== 1'b0; i++) step();
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, addr, 5'd0);
        chk({tag, "_read_en"}, read_en, 1'b0);
        chk({tag, "_write_en"}, write_en, 1'b0);
        chk({tag, "_write_can"}, write_can, 16'd0);
        chk({tag, "_rec_mes"}, rec_mes, 76'd0);
        chk({tag, "_bus_id"}, rec_bus_id, 5'd0);
        chk({tag, "_rec_valid"}, rec_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    logic [4:0]  rdq [$];
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic [75:0] held;
    int          n_wr;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        #1 rst = 1'b0;

        // Nominal frame
        fdata = '{16'hABE0, 16'h1122, 16'h3344, 16'h5566, 16'h7788};
        sel = 5'h03; rec_irq = 1'b1; rec_ready = 1'b1;
        n_wr = 0;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 0) rec_irq = 1'b0;
            if (read_en) rdq.push_back(addr);
            if (write_en) begin n_wr++; w_addr = addr; w_data = write_can; end
            if (k == 11) chk("valid_before_edge12", rec_valid, 1'b0);
            if (k == 12) chk("valid_at_edge12", rec_valid, 1'b1);
        end
        chk("nom_read_count", rdq.size(), 5);
        for (int i = 0; i < 5 && i < rdq.size(); i++) chk("nom_read_addr", rdq[i], 5'h05 - 5'(i));
        chk("nom_write_count", n_wr, 1);
        chk("nom_write_addr", w_addr, 5'h12);
        chk("nom_write_data", w_data, 16'h8070);
        chk("nom_bus_id", rec_bus_id, 5'h03);
        chk("nom_rec_mes", rec_mes, 76'h0_55F_1133_2244_8877_6655);
        chk("model_rec_mes", assemble(), 76'h0_55F_1133_2244_8877_6655);
        step();
        chk("nom_idle_after_ready", busy, 1'b0);

        // Backpressure
        rand_data();
        sel = 5'h11; rec_irq = 1'b1; rec_ready = 1'b0;
        step();
        rec_irq = 1'b0;
        wait_valid();
        held = rec_mes;
        repeat (20) begin
            step();
            chk("bp_valid_held", rec_valid, 1'b1);
            chk("bp_mes_held", rec_mes, held);
        end
        rec_ready = 1'b1;
        step();
        chk("bp_release_valid", rec_valid, 1'b0);
        chk("bp_release_busy", busy, 1'b0);

        // Reset during CAP of idx 2
        rand_data();
        sel = 5'h07; rec_irq = 1'b1;
        step();
        rec_irq = 1'b0;
        repeat (5) step();
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        step();
        rst = 1'b0;
        n_wr = 0;
        repeat (15) begin
            step();
            if (write_en) n_wr++;
        end
        chk("midrst_no_clear_write", n_wr, 0);
        rand_data();
        rec_irq = 1'b1;
        step();
        chk("restart_read_en", read_en, 1'b1);
        chk("restart_addr", addr, 5'h05);
        wait_idle();

        // Interrupt activity during a frame is ignored
        rand_data();
        sel = 5'h09; rec_irq = 1'b1; rec_ready = 1'b1;
        step();
        repeat (10) begin
            rec_irq = 1'($urandom);
            sel = 5'($urandom);
            step();
        end
        rec_irq = 1'b0;
        wait_valid();
        chk("ignored_irq_bus_id", rec_bus_id, 5'h09);
        wait_idle();

        // Back-to-back frames with rec_irq held high
        rand_data();
        sel = 5'h04; rec_irq = 1'b1; rec_ready = 1'b1;
        step();
        wait_valid();
        step();
        chk("b2b_idle", busy, 1'b0);
        rand_data();
        step();
        chk("b2b_read_en", read_en, 1'b1);
        chk("b2b_addr", addr, 5'h05);
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            if (!m_act) rand_data();
            rec_irq = ($urandom % 3 == 0);
            sel = 5'($urandom);
            rec_ready = ($urandom % 3 != 0);
            step();
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
